// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: shared widths, flag indices, ctrl codes and result types for the FPAddSub datapath
package fpaddsub_pkg;
  localparam int FP_W = 32;
  localparam int FP_FLAGS_W = 5;
  localparam int FP_TAG_W = 4;
  localparam int FLAG_INX = 0;
  localparam int FLAG_INV = 1;
  localparam int FLAG_DBZ = 2;
  localparam int FLAG_UNF = 3;
  localparam int FLAG_OVF = 4;
  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  typedef struct packed {
    logic [FP_W-1:0] z;
    logic [FP_FLAGS_W-1:0] flags;
    logic [FP_TAG_W-1:0] tag;
  } fp_result_t;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_t;
endpackage

// File: rtl/fp_skid_buf.sv
// fp_skid_buf: two-entry skid buffer with registered in_ready; main register M drives the output
module fp_skid_buf
  import fpaddsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  occ_t r_state, w_next;
  logic [W-1:0] r_m, r_s;
  logic r_in_ready, w_in_acc, w_out_acc;
  assign in_ready  = r_in_ready;
  assign out_valid = r_state != OCC_EMPTY;
  assign out_data  = r_m;
  always_comb begin
    w_in_acc  = in_valid && r_in_ready;
    w_out_acc = (r_state != OCC_EMPTY) && out_ready;
    w_next    = r_state;
    case (r_state)
      OCC_EMPTY: w_next = w_in_acc ? OCC_ONE : OCC_EMPTY;
      OCC_ONE:   w_next = (w_in_acc && !w_out_acc) ? OCC_FULL :
                          (!w_in_acc && w_out_acc) ? OCC_EMPTY : OCC_ONE;
      default:   w_next = w_out_acc ? OCC_ONE : OCC_FULL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= OCC_EMPTY;
      r_in_ready <= 1'b1;
      r_m        <= '0;
      r_s        <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_next != OCC_FULL;
      if (r_state == OCC_FULL && w_out_acc) r_m <= r_s;
      else if (w_in_acc && (r_state == OCC_EMPTY || w_out_acc)) r_m <= in_data;
      if (w_in_acc && r_state == OCC_ONE && !w_out_acc) r_s <= in_data;
    end
  end
endmodule

// File: rtl/fpaddsub_out_stage.sv
// fpaddsub_out_stage: registered FPAddSub result stage with skid buffer, sticky flags, counter and trap
module fpaddsub_out_stage
  import fpaddsub_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FP_W-1:0]       in_z,
  input  logic [FP_FLAGS_W-1:0] in_flags,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FP_W-1:0]       out_z,
  output logic [FP_FLAGS_W-1:0] out_flags,
  output logic [TAG_W-1:0]      out_tag,
  input  logic                  sticky_clr,
  output logic [FP_FLAGS_W-1:0] sticky_flags,
  input  logic [FP_FLAGS_W-1:0] trap_mask,
  output logic                  trap,
  output logic [CNT_W-1:0]      result_count
);
  localparam int W = FP_W + FP_FLAGS_W + TAG_W;
  logic w_in_acc;
  logic [W-1:0] w_out_data;
  logic [FP_FLAGS_W-1:0] r_sticky;
  logic [CNT_W-1:0] r_cnt;
  logic r_trap;
  assign w_in_acc = in_valid && in_ready;
  assign {out_z, out_flags, out_tag} = w_out_data;
  assign sticky_flags = r_sticky;
  assign result_count = r_cnt;
  assign trap = r_trap;
  fp_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_z, in_flags, in_tag}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data)
  );
  // a clear coincident with an accept still keeps the new result's flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= '0;
      r_cnt    <= '0;
      r_trap   <= 1'b0;
    end else begin
      r_sticky <= (sticky_clr ? '0 : r_sticky) | (w_in_acc ? in_flags : '0);
      r_cnt    <= w_in_acc ? r_cnt + CNT_W'(1) : r_cnt;
      r_trap   <= w_in_acc && |(in_flags & trap_mask);
    end
  end
endmodule

// File: tb/tb_fpaddsub_out_stage.sv
// tb_fpaddsub_out_stage: directed table, hand sequences and random traffic against a queue-based model
module tb_fpaddsub_out_stage;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, sticky_clr = 0, trap;
  logic [31:0] in_z = 0, out_z;
  logic [4:0] in_flags = 0, out_flags, sticky_flags, trap_mask = 0;
  logic [3:0] in_tag = 0, out_tag, result_count;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  fpaddsub_out_stage #(.TAG_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .in_flags(in_flags), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags), .out_tag(out_tag), .sticky_clr(sticky_clr),
    .sticky_flags(sticky_flags), .trap_mask(trap_mask), .trap(trap), .result_count(result_count)
  );

  typedef struct packed {logic [31:0] z; logic [4:0] fl; logic [3:0] tag;} ent_t;
  ent_t q[$];
  logic [4:0] m_sticky;
  logic [3:0] m_cnt;
  logic m_trap, m_ia, m_oa;
  logic [31:0] seen_z[$];
  logic [3:0] seen_tag[$];
  int seen_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: FIFO of at most two results, plus sticky/count/trap bookkeeping
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_sticky = 0;
      m_cnt = 0;
      m_trap = 0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("out_z", out_z, q[0].z);
        chk("out_flags", 32'(out_flags), 32'(q[0].fl));
        chk("out_tag", 32'(out_tag), 32'(q[0].tag));
      end
      chk("sticky", 32'(sticky_flags), 32'(m_sticky));
      chk("count", 32'(result_count), 32'(m_cnt));
      chk("trap", 32'(trap), 32'(m_trap));
      if (out_valid && out_ready) begin
        seen_z.push_back(out_z);
        seen_tag.push_back(out_tag);
        seen_cyc.push_back(cyc);
      end
      m_ia = in_valid && q.size() < 2;
      m_oa = out_ready && q.size() > 0;
      if (m_oa) void'(q.pop_front());
      if (m_ia) q.push_back({in_z, in_flags, in_tag});
      m_sticky = (sticky_clr ? 5'b0 : m_sticky) | (m_ia ? in_flags : 5'b0);
      if (m_ia) m_cnt = m_cnt + 4'd1;
      m_trap = m_ia && ((in_flags & trap_mask) != 5'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] z, input logic [4:0] fl, input logic [3:0] tag);
    int n = 0;
    in_valid = 1; in_z = z; in_flags = fl; in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck 0 for tag %0d, required 1", tag);
    end
    tick();
  endtask

  typedef struct {
    logic [31:0] z; logic [4:0] fl; logic [3:0] tag; logic [4:0] mask; logic clr;
    logic [4:0] e_sticky; logic e_trap; logic [3:0] e_cnt;
  } vec_t;
  vec_t tv[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{32'h40000000, 5'b00000, 4'd1, 5'b10000, 1'b0, 5'b00000, 1'b0, 4'd1};
    tv[1] = '{32'h3F800000, 5'b00001, 4'd2, 5'b10000, 1'b0, 5'b00001, 1'b0, 4'd2};
    tv[2] = '{32'h40400000, 5'b10000, 4'd3, 5'b10000, 1'b0, 5'b10001, 1'b1, 4'd3};
    tv[3] = '{32'h40800000, 5'b00100, 4'd4, 5'b10000, 1'b1, 5'b00100, 1'b0, 4'd4};
    tv[4] = '{32'hC0000000, 5'b00010, 4'd5, 5'b00010, 1'b0, 5'b00110, 1'b1, 4'd5};
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_z", out_z, 0);
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_z = tv[i].z; in_flags = tv[i].fl; in_tag = tv[i].tag;
      trap_mask = tv[i].mask; sticky_clr = tv[i].clr;
      tick();
      chk($sformatf("tv%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("tv%0d_z", i), out_z, tv[i].z);
      chk($sformatf("tv%0d_tag", i), 32'(out_tag), 32'(tv[i].tag));
      chk($sformatf("tv%0d_sticky", i), 32'(sticky_flags), 32'(tv[i].e_sticky));
      chk($sformatf("tv%0d_trap", i), 32'(trap), 32'(tv[i].e_trap));
      chk($sformatf("tv%0d_cnt", i), 32'(result_count), 32'(tv[i].e_cnt));
    end
    in_valid = 0; sticky_clr = 0; trap_mask = 0;
    tick();
    chk("trap_idle", 32'(trap), 0);
    tick();
    seen_z.delete(); seen_tag.delete(); seen_cyc.delete();
    out_ready = 0;
    send(32'h40800000, 0, 1);
    send(32'h40400000, 0, 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_head", out_z, 32'h40800000);
    in_valid = 1; in_z = 32'h3F800000; in_tag = 3;
    repeat (2) tick();
    chk("bp_hold_z", out_z, 32'h40800000);
    chk("bp_hold_tag", 32'(out_tag), 1);
    out_ready = 1;
    send(32'h3F800000, 0, 3);
    in_valid = 0;
    repeat (4) tick();
    chk("bp_count", seen_z.size(), 3);
    if (seen_z.size() == 3) begin
      chk("bp_out0", seen_z[0], 32'h40800000);
      chk("bp_out1", seen_z[1], 32'h40400000);
      chk("bp_out2", seen_z[2], 32'h3F800000);
    end
    seen_z.delete(); seen_tag.delete(); seen_cyc.delete();
    for (int t = 0; t < 8; t++) begin
      send(32'h41000000 + t, 0, 4'(t));
      chk("stream_in_ready", 32'(in_ready), 1);
    end
    in_valid = 0;
    tick();
    chk("stream_count", seen_tag.size(), 8);
    if (seen_tag.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("stream_tag", 32'(seen_tag[i]), i);
        chk("stream_cycle", seen_cyc[i], seen_cyc[0] + i);
      end
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 17; i++) send($urandom, 0, 4'(i));
    in_valid = 0;
    chk("wrap_count", 32'(result_count), 1);
    repeat (400) begin
      in_valid = ($urandom % 4) != 0;
      in_z = $urandom;
      in_flags = 5'($urandom);
      in_tag = 4'($urandom);
      out_ready = ($urandom % 3) != 0;
      trap_mask = 5'($urandom);
      sticky_clr = ($urandom % 8) == 0;
      tick();
    end
    in_valid = 0; sticky_clr = 0; out_ready = 1;
    repeat (3) tick();
    out_ready = 0;
    send(32'h40000000, 5'b01000, 6);
    send(32'h40400000, 5'b00010, 7);
    in_valid = 1; in_z = 32'h3F800000; in_tag = 8;
    rst = 1;
    tick();
    rst = 0; in_valid = 0;
    chk("rstfull_out_valid", 32'(out_valid), 0);
    chk("rstfull_in_ready", 32'(in_ready), 1);
    chk("rstfull_sticky", 32'(sticky_flags), 0);
    chk("rstfull_count", 32'(result_count), 0);
    seen_z.delete(); seen_tag.delete(); seen_cyc.delete();
    out_ready = 1;
    repeat (5) tick();
    chk("rstfull_no_stale", seen_z.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
